// File: rtl/wfg_record_spi_pkg.sv
// Shared types and helpers for the SPI recorder: FSM states, frame-length encoding
// and the DFF-to-bit-count decode.
package wfg_record_spi_pkg;

    localparam int unsigned SHIFT_W   = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned POS_W     = 5;
    localparam int unsigned OVF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_PUSH = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        DFF_8  = 2'b00,
        DFF_16 = 2'b01,
        DFF_24 = 2'b10,
        DFF_32 = 2'b11
    } dff_e;

    // Number of SPI bits in one frame for a given DFF encoding
    function automatic logic [CNT_W-1:0] frame_len(input dff_e dff);
        logic [CNT_W-1:0] len;
        case (dff)
            DFF_8:   len = CNT_W'(8);
            DFF_16:  len = CNT_W'(16);
            DFF_24:  len = CNT_W'(24);
            default: len = CNT_W'(32);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/wfg_record_spi_if.sv
// AXI-Stream handshake bundle carrying recorded SPI words out of the recorder.
interface wfg_record_spi_if #(
    parameter int unsigned AXIS_DATA_WIDTH = 32
);

    logic                       wfg_axis_tvalid_o;
    logic                       wfg_axis_tready_i;
    logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o;

    modport master (
        output wfg_axis_tvalid_o,
        output wfg_axis_tdata_o,
        input  wfg_axis_tready_i
    );

    modport slave (
        input  wfg_axis_tvalid_o,
        input  wfg_axis_tdata_o,
        output wfg_axis_tready_i
    );

endinterface

// File: rtl/wfg_record_spi_sync.sv
// Two-flop synchronizer for asynchronous inputs, reset to zero.
module wfg_record_spi_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wfg_record_spi.sv
// SPI slave recorder: deserializes SPI frames into AXI-Stream words.
// Optional overflow counter enabled by defining WFG_RECORD_SPI_OVF_CNT_EN.
module wfg_record_spi
    import wfg_record_spi_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctrl_en_q_i,
    input  logic                 cfg_cpol_q_i,
    input  logic                 cfg_lsbfirst_q_i,
    input  logic [1:0]           cfg_dff_q_i,
    input  logic                 cfg_sspol_q_i,
    input  logic                 status_clr_i,
    input  logic                 wfg_record_spi_sclk_i,
    input  logic                 wfg_record_spi_cs_i,
    input  logic                 wfg_record_spi_sdi_i,
    wfg_record_spi_if.master     axis,
    output logic                 status_ovf_o,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

    logic [2:0] pins_s;
    logic       sclk_s, cs_s, sdi_s;

    wfg_record_spi_sync #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({wfg_record_spi_sclk_i, wfg_record_spi_cs_i, wfg_record_spi_sdi_i}),
        .q     (pins_s)
    );

    assign sclk_s = pins_s[2];
    assign cs_s   = pins_s[1];
    assign sdi_s  = pins_s[0];

    state_e                     state_q, state_n;
    logic                       sclk_q;
    logic                       armed_q, armed_n;
    logic                       cpol_q, cpol_n;
    logic                       lsb_q, lsb_n;
    logic                       sspol_q, sspol_n;
    dff_e                       dff_q, dff_n;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_n;
    logic [SHIFT_W-1:0]         sr_q, sr_n;
    logic                       tvalid_q, tvalid_n;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_n;
    logic                       ovf_q, ovf_n;
    logic                       overflow_c;
    logic                       sample_edge_c;
    logic                       cs_act_c;
    logic [POS_W-1:0]           pos_c;

    always_comb begin
        sample_edge_c = cpol_q ? (sclk_q & ~sclk_s) : (sclk_s & ~sclk_q);
        cs_act_c      = (cs_s == sspol_q);
        pos_c         = lsb_q ? POS_W'(bit_cnt_q)
                              : POS_W'(frame_len(dff_q) - CNT_W'(1) - bit_cnt_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        armed_n    = armed_q;
        cpol_n     = cpol_q;
        lsb_n      = lsb_q;
        sspol_n    = sspol_q;
        dff_n      = dff_q;
        bit_cnt_n  = bit_cnt_q;
        sr_n       = sr_q;
        tvalid_n   = tvalid_q;
        tdata_n    = tdata_q;
        ovf_n      = ovf_q;
        overflow_c = 1'b0;

        if (tvalid_q && axis.wfg_axis_tready_i) tvalid_n = 1'b0;
        if (status_clr_i) ovf_n = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A burst starts only after CS has been seen inactive, so a frame
                // already in flight (e.g. across reset) is never picked up halfway.
                if (cs_s != cfg_sspol_q_i) begin
                    armed_n = 1'b1;
                end else if (armed_q && ctrl_en_q_i) begin
                    state_n   = ST_RECV;
                    armed_n   = 1'b0;
                    cpol_n    = cfg_cpol_q_i;
                    lsb_n     = cfg_lsbfirst_q_i;
                    sspol_n   = cfg_sspol_q_i;
                    dff_n     = dff_e'(cfg_dff_q_i);
                    bit_cnt_n = '0;
                    sr_n      = '0;
                end
            end
            ST_RECV: begin
                if (!cs_act_c) begin
                    state_n   = ST_IDLE;
                    bit_cnt_n = '0;
                    sr_n      = '0;
                end else if (sample_edge_c) begin
                    sr_n[pos_c] = sdi_s;
                    bit_cnt_n   = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q + CNT_W'(1) == frame_len(dff_q)) state_n = ST_PUSH;
                end
            end
            ST_PUSH: begin
                // A transfer this cycle frees the register, so only a stalled beat drops
                if (tvalid_q && !axis.wfg_axis_tready_i) begin
                    overflow_c = 1'b1;
                end else begin
                    tvalid_n = 1'b1;
                    tdata_n  = AXIS_DATA_WIDTH'(sr_q);
                end
                sr_n      = '0;
                bit_cnt_n = '0;
                state_n   = cs_act_c ? ST_RECV : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (!ctrl_en_q_i) begin
            state_n    = ST_IDLE;
            bit_cnt_n  = '0;
            sr_n       = '0;
            tvalid_n   = 1'b0;
            tdata_n    = '0;
            overflow_c = 1'b0;
        end

        if (overflow_c) ovf_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            armed_q   <= 1'b0;
            cpol_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sspol_q   <= 1'b0;
            dff_q     <= DFF_8;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            sclk_q    <= sclk_s;
            armed_q   <= armed_n;
            cpol_q    <= cpol_n;
            lsb_q     <= lsb_n;
            sspol_q   <= sspol_n;
            dff_q     <= dff_n;
            bit_cnt_q <= bit_cnt_n;
            sr_q      <= sr_n;
            tvalid_q  <= tvalid_n;
            tdata_q   <= tdata_n;
            ovf_q     <= ovf_n;
        end
    end

    assign axis.wfg_axis_tvalid_o = tvalid_q;
    assign axis.wfg_axis_tdata_o  = tdata_q;
    assign status_ovf_o           = ovf_q;

`ifdef WFG_RECORD_SPI_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // Dropped-word counter, saturating; a drop in the clearing cycle still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (overflow_c) begin
            if (status_clr_i)             ovf_cnt_q <= OVF_CNT_W'(1);
            else if (ovf_cnt_q != '1)     ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
        end else if (status_clr_i) begin
            ovf_cnt_q <= '0;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wfg_record_spi.sv
// Directed bench for wfg_record_spi: SPI frames driven bit by bit, beats checked
// against a queue of expected words.
module tb_wfg_record_spi;

    localparam int HALF = 4;  // SCLK half period in clk cycles

`ifdef WFG_RECORD_SPI_OVF_CNT_EN
    localparam logic [31:0] OVF_CNT_ONE = 32'd1;
`else
    localparam logic [31:0] OVF_CNT_ONE = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, cpol, lsb, sspol, status_clr;
    logic [1:0] dff;
    logic       sclk, cs, sdi;
    logic       ovf;
    logic [7:0] ovf_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    wfg_record_spi_if #(.AXIS_DATA_WIDTH(32)) axis ();

    wfg_record_spi #(.AXIS_DATA_WIDTH(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ctrl_en_q_i           (en),
        .cfg_cpol_q_i          (cpol),
        .cfg_lsbfirst_q_i      (lsb),
        .cfg_dff_q_i           (dff),
        .cfg_sspol_q_i         (sspol),
        .status_clr_i          (status_clr),
        .wfg_record_spi_sclk_i (sclk),
        .wfg_record_spi_cs_i   (cs),
        .wfg_record_spi_sdi_i  (sdi),
        .axis                  (axis),
        .status_ovf_o          (ovf),
        .ovf_cnt_o             (ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && axis.wfg_axis_tvalid_o && axis.wfg_axis_tready_i) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("beat_data", axis.wfg_axis_tdata_o, exp_q.pop_front());
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_on();
        cs = sspol;
        wait_clk(4);
    endtask

    task automatic cs_off();
        cs = ~sspol;
        wait_clk(4);
    endtask

    // mode 1: check tvalid latency on the last bit; mode 2: pulse clear in the push cycle
    task automatic send_bits(input logic [31:0] word, input int n, input int from,
                             input int to, input int mode);
        for (int k = from; k < to; k++) begin
            sdi = lsb ? word[k] : word[n-1-k];
            wait_clk(HALF);
            sclk = ~cpol;
            if (k == to - 1 && mode == 1) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("latency_edge3", 32'(axis.wfg_axis_tvalid_o), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("latency_edge4", 32'(axis.wfg_axis_tvalid_o), 32'd1);
                wait_clk(1);
            end else if (k == to - 1 && mode == 2) begin
                repeat (3) @(posedge clk);
                #1 status_clr = 1'b1;
                @(posedge clk);
                #1 status_clr = 1'b0;
                wait_clk(1);
            end else begin
                wait_clk(HALF);
            end
            sclk = cpol;
        end
    endtask

    task automatic frame(input logic [31:0] word, input int n, input int mode);
        cs_on();
        send_bits(word, n, 0, n, mode);
        wait_clk(HALF);
        cs_off();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cpol = 1'b0; lsb = 1'b0; sspol = 1'b0;
        dff = 2'b00; status_clr = 1'b0; sclk = 1'b0; cs = 1'b1; sdi = 1'b0;
        axis.wfg_axis_tready_i = 1'b1;

        // Reset state
        wait_clk(3);
        @(negedge clk);
        check("rst_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd0);
        check("rst_tdata", axis.wfg_axis_tdata_o, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(6);

        // CPOL0, MSB-first, 8-bit with latency check
        exp_q.push_back(32'h0000_00A5);
        frame(32'hA5, 8, 1);
        wait_clk(4);

        // CPOL1, LSB-first, 32-bit
        cpol = 1'b1; lsb = 1'b1; dff = 2'b11; sclk = 1'b1;
        wait_clk(4);
        exp_q.push_back(32'h1234_5678);
        frame(32'h1234_5678, 32, 0);
        wait_clk(4);

        // 16-bit overflow with a stalled sink
        cpol = 1'b0; lsb = 1'b0; dff = 2'b01; sclk = 1'b0;
        axis.wfg_axis_tready_i = 1'b0;
        wait_clk(4);
        exp_q.push_back(32'h0000_1111);
        frame(32'h1111, 16, 0);
        frame(32'h2222, 16, 0);
        @(negedge clk);
        check("ovf_hold_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd1);
        check("ovf_hold_tdata", axis.wfg_axis_tdata_o, 32'h0000_1111);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_cnt", 32'(ovf_cnt), OVF_CNT_ONE);
        wait_clk(1);
        axis.wfg_axis_tready_i = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check("ovf_drained_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd0);
        wait_clk(1);
        status_clr = 1'b1;
        wait_clk(1);
        status_clr = 1'b0;
        @(negedge clk);
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
        wait_clk(1);

        // 24-bit: aborted partial frame, then a complete one
        dff = 2'b10;
        wait_clk(2);
        cs_on();
        send_bits(32'h0055_AA55, 24, 0, 10, 0);
        cs_off();
        exp_q.push_back(32'h00AB_CDEF);
        frame(32'hABCDEF, 24, 0);
        wait_clk(4);

        // Clear coincident with an overflow event: set wins
        dff = 2'b00;
        axis.wfg_axis_tready_i = 1'b0;
        wait_clk(2);
        exp_q.push_back(32'h0000_0011);
        frame(32'h11, 8, 0);
        frame(32'h22, 8, 2);
        @(negedge clk);
        check("clr_vs_set_ovf", 32'(ovf), 32'd1);
        check("clr_vs_set_cnt", 32'(ovf_cnt), OVF_CNT_ONE);
        check("clr_vs_set_tdata", axis.wfg_axis_tdata_o, 32'h0000_0011);
        wait_clk(1);
        axis.wfg_axis_tready_i = 1'b1;
        wait_clk(4);

        // Enable drop with a pending word
        axis.wfg_axis_tready_i = 1'b0;
        frame(32'h5A, 8, 0);
        @(negedge clk);
        check("en_pending_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd1);
        check("en_pending_tdata", axis.wfg_axis_tdata_o, 32'h0000_005A);
        wait_clk(1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_off_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd0);
        check("en_off_tdata", axis.wfg_axis_tdata_o, 32'd0);
        check("en_off_ovf_kept", 32'(ovf), 32'd1);
        wait_clk(2);
        en = 1'b1;
        axis.wfg_axis_tready_i = 1'b1;
        wait_clk(10);
        exp_q.push_back(32'h0000_003C);
        frame(32'h3C, 8, 0);
        status_clr = 1'b1;
        wait_clk(1);
        status_clr = 1'b0;
        @(negedge clk);
        check("clr_ovf_again", 32'(ovf), 32'd0);
        wait_clk(1);

        // Reset mid-frame with a pending word
        axis.wfg_axis_tready_i = 1'b0;
        frame(32'h77, 8, 0);
        cs_on();
        send_bits(32'h96, 8, 0, 4, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd0);
        check("rst_async_tdata", axis.wfg_axis_tdata_o, 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        axis.wfg_axis_tready_i = 1'b1;
        send_bits(32'h96, 8, 4, 8, 0);
        send_bits(32'hFF, 8, 0, 8, 0);
        wait_clk(HALF);
        cs_off();
        wait_clk(10);
        @(negedge clk);
        check("post_rst_tvalid", 32'(axis.wfg_axis_tvalid_o), 32'd0);
        wait_clk(1);
        exp_q.push_back(32'h0000_00C3);
        frame(32'hC3, 8, 0);
        wait_clk(10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
